cdb_tag_tracker: RTL

- Receiving end of the common data bus (CDB).
- Allocates result tags to issuing instructions and publishes the per-register pending-tag table (regState) consumed by the execution units.
- Captures CDB broadcasts, writes results back to the register heap and frees the tags.
- Sits between the issue stage and the register heap write port; it is the sole CDB listener that retires tags.

---
 rtl/cdb_tag_tracker.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/cdb_tag_tracker.sv
// cdb_tag_tracker: receiving end of the common data bus.
// Allocates result tags to issuing instructions, publishes the per-register
// pending-tag table, captures CDB broadcasts, writes results back to the
// register heap and frees the tags.
// Optional build macro: CDB_TAG_CHECK_EN adds the sticky tagErr output that
// flags spurious broadcasts (free tag on the bus) and issue overflow.
module cdb_tag_tracker #(
   parameter int TAG_W = 3,
   parameter int REG_N = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   issueValid,
   input  logic [4:0]             issueRd,
   output logic                   issueReady,
   output logic [TAG_W-1:0]       issueTag,
   output logic [REG_N*TAG_W-1:0] regState,
   input  logic [31:0]            cdbData,
   input  logic [TAG_W-1:0]       cdbId,
   input  logic                   cdbInt,
   output logic                   wbEn,
   output logic [4:0]             wbAddr,
   output logic [31:0]            wbData,
`ifdef CDB_TAG_CHECK_EN
   output logic                   tagErr,
`endif
   output logic [TAG_W-1:0]       busyCount
);

   localparam int TAG_N = 1 << TAG_W;

   // busy_reg[0] is never set: tag 0 is the "no producer" marker
   logic [TAG_N-1:0]  busy_reg;
   logic [TAG_N-1:0]  busy_next;
   logic [4:0]        dest_reg [TAG_N];
   logic [TAG_W-1:0]  rs_reg   [REG_N];
   logic [TAG_W-1:0]  busy_count_reg;
   logic              wb_en_reg;
   logic [4:0]        wb_addr_reg;
   logic [31:0]       wb_data_reg;

   logic              alloc;
   logic              capture;
   logic [4:0]        cap_dest;
   logic              free_found;
   logic [TAG_W-1:0]  free_tag;

   // Lowest-numbered free tag among 1..TAG_N-1 (scan downward so the lowest wins)
   always_comb begin
      free_found = 1'b0;
      free_tag   = '0;
      for (int t = TAG_N - 1; t >= 1; t--) begin
         if (!busy_reg[t]) begin
            free_found = 1'b1;
            free_tag   = TAG_W'(t);
         end
      end
   end

   assign issueReady = free_found;
   assign issueTag   = free_tag;

   assign alloc    = issueValid && issueReady;
   // Internal traffic, idle bus and broadcasts naming a free tag are ignored
   assign capture  = (cdbId != '0) && !cdbInt && busy_reg[cdbId];
   assign cap_dest = dest_reg[cdbId];

   // Next busy map: the allocated tag is free and the captured one busy, so
   // the two updates never touch the same bit.
   always_comb begin
      busy_next = busy_reg;
      if (capture) busy_next[cdbId] = 1'b0;
      if (alloc)   busy_next[free_tag] = 1'b1;
      busy_next[0] = 1'b0;
   end

   // Tag bookkeeping: busy map, destination per tag and allocation count
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         busy_reg       <= '0;
         busy_count_reg <= '0;
         for (int t = 0; t < TAG_N; t++) dest_reg[t] <= '0;
      end else begin
         busy_reg <= busy_next;
         if (alloc) dest_reg[free_tag] <= issueRd;
         if (alloc && !capture)
            busy_count_reg <= busy_count_reg + 1'b1;
         else if (capture && !alloc)
            busy_count_reg <= busy_count_reg - 1'b1;
      end
   end

   assign busyCount = busy_count_reg;

   // Register heap write port: one pulse per accepted capture, data held otherwise
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wb_en_reg   <= 1'b0;
         wb_addr_reg <= '0;
         wb_data_reg <= '0;
      end else begin
         wb_en_reg <= 1'b0;
         if (capture) begin
            wb_en_reg   <= (cap_dest != 5'd0);
            wb_addr_reg <= cap_dest;
            wb_data_reg <= cdbData;
         end
      end
   end

   assign wbEn   = wb_en_reg;
   assign wbAddr = wb_addr_reg;
   assign wbData = wb_data_reg;

   // Register 0 is hardwired and never renamed
   always_comb rs_reg[0] = '0;
   assign regState[TAG_W-1:0] = '0;

   generate
      for (genvar gi = 1; gi < REG_N; gi++) begin : g_reg
         // Pending tag for register gi: a new rename wins over a capture, and a
         // capture only clears the field if it still names the broadcast tag.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               rs_reg[gi] <= '0;
            end else if (alloc && (issueRd == 5'(gi))) begin
               rs_reg[gi] <= free_tag;
            end else if (capture && (cap_dest == 5'(gi)) && (rs_reg[gi] == cdbId)) begin
               rs_reg[gi] <= '0;
            end
         end
         assign regState[gi*TAG_W +: TAG_W] = rs_reg[gi];
      end
   endgenerate

`ifdef CDB_TAG_CHECK_EN
   logic tag_err_reg;

   // Sticky error: spurious broadcast of a free tag, or issue while full
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_err_reg <= 1'b0;
      end else if (((cdbId != '0) && !cdbInt && !busy_reg[cdbId]) ||
                   (issueValid && !issueReady)) begin
         tag_err_reg <= 1'b1;
      end
   end

   assign tagErr = tag_err_reg;
`endif

endmodule
